// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter.
//   mode_e  : operation codes carried on MODE (SLL, SRL, SRA, ROL)
//   state_e : control FSM encodings (IDLE, SHIFT, FIN)
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_FIN   = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a WIDTH-bit word by k bits in
// the selected mode and reports the last bit pushed out of the word.
//   data    : word to shift
//   mode    : SLL / SRL / SRA / ROL
//   k       : distance for this step (0 leaves data unchanged, out_bit=0)
//   result  : shifted word, truncated to WIDTH bits
//   out_bit : final bit shifted/rotated out (MSB side for SLL/ROL,
//             LSB side for SRL/SRA)
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         data,
    input  mode_e                    mode,
    input  logic [$clog2(WIDTH)-1:0] k,
    output logic [WIDTH-1:0]         result,
    output logic                     out_bit
);

    localparam int AW = $clog2(WIDTH);

    // One guard bit on the exit side catches the last bit shifted out;
    // with k=0 the guard stays 0, which gives out_bit=0 for free.
    logic [WIDTH:0]        left_ext;
    logic [WIDTH:0]        right_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0]      rol_word;
    logic [AW:0]           rot_back;

    always_comb begin
        left_ext  = {1'b0, data} << k;
        right_ext = {data, 1'b0} >> k;
        sra_ext   = $signed({data, 1'b0}) >>> k;
        // For k=0 the wrap term shifts by WIDTH and vanishes.
        rot_back  = (AW+1)'(WIDTH) - {1'b0, k};
        rol_word  = (data << k) | (data >> rot_back);

        result  = data;
        out_bit = 1'b0;
        unique case (mode)
            MODE_SLL: begin
                result  = left_ext[WIDTH-1:0];
                out_bit = left_ext[WIDTH];
            end
            MODE_SRL: begin
                result  = right_ext[WIDTH:1];
                out_bit = right_ext[0];
            end
            MODE_SRA: begin
                result  = sra_ext[WIDTH:1];
                out_bit = sra_ext[0];
            end
            MODE_ROL: begin
                // Last bit rotated out of the MSB lands in bit 0.
                result  = rol_word;
                out_bit = (k != '0) && rol_word[0];
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-less shifter: applies up to STEP bits of shift per
// clock until AMOUNT bits have been consumed.
//   CLK, RST_N : clock, asynchronous active-low reset
//   START      : request, accepted in IDLE or FIN
//   MODE       : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   AMOUNT     : shift distance 0..WIDTH-1
//   INPUT      : operand
//   BUSY       : high while shifting (SHIFT state)
//   DONE       : one-cycle pulse, OUTPUT/CARRY final
//   OUTPUT     : working/result register, held until the next accept
//   CARRY      : last bit shifted out, 0 for AMOUNT=0
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     START,
    input  logic [1:0]               MODE,
    input  logic [$clog2(WIDTH)-1:0] AMOUNT,
    input  logic [WIDTH-1:0]         INPUT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [WIDTH-1:0]         OUTPUT,
    output logic                     CARRY
);

    localparam int          AW     = $clog2(WIDTH);
    // STEP may equal WIDTH, which does not fit in AW bits.
    localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

    state_e          state, state_next;
    mode_e           mode_q;
    logic [AW-1:0]   remaining;
    logic [AW-1:0]   k;
    logic            last_step;
    logic            accept;
    logic [WIDTH-1:0] step_result;
    logic            step_out;

    // min(STEP, remaining); the STEP branch is only taken when STEP fits.
    assign k         = ({1'b0, remaining} < STEP_W) ? remaining : STEP_W[AW-1:0];
    assign last_step = ({1'b0, remaining} <= STEP_W);
    assign accept    = START && ((state == ST_IDLE) || (state == ST_FIN));

    assign BUSY = (state == ST_SHIFT);
    assign DONE = (state == ST_FIN);

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data    (OUTPUT),
        .mode    (mode_q),
        .k       (k),
        .result  (step_result),
        .out_bit (step_out)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_next = (AMOUNT == '0) ? ST_FIN : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_step) state_next = ST_FIN;
            end
            ST_FIN: begin
                if (accept) state_next = (AMOUNT == '0) ? ST_FIN : ST_SHIFT;
                else        state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // OUTPUT doubles as the working register: it only moves on accept and
    // on SHIFT edges, so it is final and stable whenever DONE is high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUTPUT    <= '0;
            CARRY     <= 1'b0;
            mode_q    <= MODE_SLL;
            remaining <= '0;
        end else if (accept) begin
            OUTPUT    <= INPUT;
            CARRY     <= 1'b0;
            mode_q    <= mode_e'(MODE);
            remaining <= AMOUNT;
        end else if (state == ST_SHIFT) begin
            OUTPUT    <= step_result;
            CARRY     <= step_out;
            remaining <= remaining - k;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [1:0]  MODE;
    logic [3:0]  AMOUNT;
    logic [15:0] INPUT;

    logic        busy1, done1, carry1;
    logic [15:0] out1;
    logic        busy4, done4, carry4;
    logic [15:0] out4;

    logic        use4;
    logic        busy_s, done_s, carry_s;
    logic [15:0] out_s;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    seq_shifter #(.WIDTH(16), .STEP(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .AMOUNT(AMOUNT),
        .INPUT(INPUT), .BUSY(busy1), .DONE(done1), .OUTPUT(out1), .CARRY(carry1)
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .AMOUNT(AMOUNT),
        .INPUT(INPUT), .BUSY(busy4), .DONE(done4), .OUTPUT(out4), .CARRY(carry4)
    );

    assign busy_s  = use4 ? busy4  : busy1;
    assign done_s  = use4 ? done4  : done1;
    assign out_s   = use4 ? out4   : out1;
    assign carry_s = use4 ? carry4 : carry1;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Issues one request (edge 0) and counts edges until DONE, bounded.
    task automatic run_op(input logic [1:0] m, input logic [3:0] a, input logic [15:0] d,
                          output int edges, output int busy_n);
        MODE = m; AMOUNT = a; INPUT = d; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        edges = 0; busy_n = 0;
        while (done_s !== 1'b1 && edges < 40) begin
            if (busy_s === 1'b1) busy_n++;
            @(posedge CLK); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0; START = 1'b0; MODE = SLL; AMOUNT = '0; INPUT = '0; use4 = 1'b0;
        #2;
        checks++; if (busy1 !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
        checks++; if (done1 !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
        checks++; if (out1 !== 16'h0)   begin errors++; $display("FAIL reset_out: got %h expected 0000", out1); end
        checks++; if (carry1 !== 1'b0)  begin errors++; $display("FAIL reset_carry: got %b expected 0", carry1); end
        checks++; if (out4 !== 16'h0)   begin errors++; $display("FAIL reset_out4: got %h expected 0000", out4); end
        idle(2);
        RST_N = 1'b1;
        idle(1);
    endtask

    task automatic test_sll;
        int e, b;
        use4 = 1'b0; idle(16);
        run_op(SLL, 4'd1, 16'd100, e, b);
        checks++; if (e != 1)             begin errors++; $display("FAIL sll_edges: got %0d expected 1", e); end
        checks++; if (out1 !== 16'd200)   begin errors++; $display("FAIL sll_out: got %h expected 00c8", out1); end
        checks++; if (carry1 !== 1'b0)    begin errors++; $display("FAIL sll_carry: got %b expected 0", carry1); end
        checks++; if (busy1 !== 1'b0)     begin errors++; $display("FAIL sll_busy_at_done: got %b expected 0", busy1); end
        idle(1);
        checks++; if (done1 !== 1'b0)     begin errors++; $display("FAIL sll_done_pulse: got %b expected 0", done1); end
        checks++; if (out1 !== 16'd200)   begin errors++; $display("FAIL sll_hold: got %h expected 00c8", out1); end
        run_op(SLL, 4'd1, 16'hFFFF, e, b);
        checks++; if (out1 !== 16'hFFFE)  begin errors++; $display("FAIL sll_ff_out: got %h expected fffe", out1); end
        checks++; if (carry1 !== 1'b1)    begin errors++; $display("FAIL sll_ff_carry: got %b expected 1", carry1); end
    endtask

    task automatic test_right;
        int e, b;
        use4 = 1'b0; idle(16);
        run_op(SRA, 4'd15, 16'h8000, e, b);
        checks++; if (b != 15)            begin errors++; $display("FAIL sra_busy_cycles: got %0d expected 15", b); end
        checks++; if (e != 15)            begin errors++; $display("FAIL sra_edges: got %0d expected 15", e); end
        checks++; if (out1 !== 16'hFFFF)  begin errors++; $display("FAIL sra_out: got %h expected ffff", out1); end
        checks++; if (carry1 !== 1'b0)    begin errors++; $display("FAIL sra_carry: got %b expected 0", carry1); end
        idle(2);
        run_op(SRL, 4'd15, 16'h8000, e, b);
        checks++; if (out1 !== 16'h0001)  begin errors++; $display("FAIL srl_msb_out: got %h expected 0001", out1); end
        idle(2);
        run_op(SRL, 4'd5, 16'h00F0, e, b);
        checks++; if (out1 !== 16'h0007)  begin errors++; $display("FAIL srl_out: got %h expected 0007", out1); end
        checks++; if (carry1 !== 1'b1)    begin errors++; $display("FAIL srl_carry: got %b expected 1", carry1); end
    endtask

    task automatic test_rol_step4;
        int e, b;
        use4 = 1'b1; idle(16);
        run_op(ROL, 4'd4, 16'h8001, e, b);
        checks++; if (e != 1)             begin errors++; $display("FAIL rol4_edges: got %0d expected 1", e); end
        checks++; if (out4 !== 16'h0018)  begin errors++; $display("FAIL rol4_out: got %h expected 0018", out4); end
        checks++; if (carry4 !== 1'b0)    begin errors++; $display("FAIL rol4_carry: got %b expected 0", carry4); end
        idle(2);
        run_op(ROL, 4'd6, 16'h8001, e, b);
        checks++; if (e != 2)             begin errors++; $display("FAIL rol6_edges: got %0d expected 2", e); end
        checks++; if (out4 !== 16'h0060)  begin errors++; $display("FAIL rol6_out: got %h expected 0060", out4); end
        idle(2);
        run_op(ROL, 4'd1, 16'h8001, e, b);
        checks++; if (out4 !== 16'h0003)  begin errors++; $display("FAIL rol1_out: got %h expected 0003", out4); end
        checks++; if (carry4 !== 1'b1)    begin errors++; $display("FAIL rol1_carry: got %b expected 1", carry4); end
        idle(2);
        run_op(SLL, 4'd15, 16'h0001, e, b);
        checks++; if (e != 4)             begin errors++; $display("FAIL sll15_s4_edges: got %0d expected 4", e); end
        checks++; if (out4 !== 16'h8000)  begin errors++; $display("FAIL sll15_s4_out: got %h expected 8000", out4); end
        idle(2);
        run_op(SRA, 4'd7, 16'hF000, e, b);
        checks++; if (out4 !== 16'hFFE0)  begin errors++; $display("FAIL sra7_s4_out: got %h expected ffe0", out4); end
        checks++; if (carry4 !== 1'b0)    begin errors++; $display("FAIL sra7_s4_carry: got %b expected 0", carry4); end
    endtask

    task automatic test_zero_amount;
        int e, b;
        logic [1:0] m;
        use4 = 1'b0; idle(16);
        for (int i = 0; i < 4; i++) begin
            // Leave CARRY=1 first so the zero-distance clear is visible.
            run_op(SLL, 4'd1, 16'hFFFF, e, b);
            idle(1);
            m = 2'(i);
            run_op(m, 4'd0, 16'h1234, e, b);
            checks++; if (e != 0)            begin errors++; $display("FAIL zero_edges[%0d]: got %0d expected 0", i, e); end
            checks++; if (b != 0)            begin errors++; $display("FAIL zero_busy[%0d]: got %0d expected 0", i, b); end
            checks++; if (out1 !== 16'h1234) begin errors++; $display("FAIL zero_out[%0d]: got %h expected 1234", i, out1); end
            checks++; if (carry1 !== 1'b0)   begin errors++; $display("FAIL zero_carry[%0d]: got %b expected 0", i, carry1); end
            idle(1);
        end
    endtask

    task automatic test_busy_ignore;
        int e;
        use4 = 1'b0; idle(16);
        MODE = SLL; AMOUNT = 4'd8; INPUT = 16'h0001; START = 1'b1;
        @(posedge CLK); #1;              // edge 0
        START = 1'b0;
        idle(2);                         // edges 1, 2
        MODE = ROL; AMOUNT = 4'd1; INPUT = 16'hFFFF; START = 1'b1;
        @(posedge CLK); #1;              // edge 3
        START = 1'b0;
        checks++; if (busy1 !== 1'b1)    begin errors++; $display("FAIL ignore_busy: got %b expected 1", busy1); end
        e = 3;
        while (done1 !== 1'b1 && e < 40) begin
            @(posedge CLK); #1;
            e++;
        end
        checks++; if (e != 8)            begin errors++; $display("FAIL ignore_edges: got %0d expected 8", e); end
        checks++; if (out1 !== 16'h0100) begin errors++; $display("FAIL ignore_out: got %h expected 0100", out1); end
        checks++; if (carry1 !== 1'b0)   begin errors++; $display("FAIL ignore_carry: got %b expected 0", carry1); end
    endtask

    task automatic test_reset_abort;
        int e, b, dones;
        use4 = 1'b0; idle(16);
        MODE = SLL; AMOUNT = 4'd8; INPUT = 16'h00FF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        idle(3);                         // edges 1..3
        checks++; if (out1 !== 16'h07F8) begin errors++; $display("FAIL abort_mid_out: got %h expected 07f8", out1); end
        RST_N = 1'b0;
        #1;
        checks++; if (out1 !== 16'h0)    begin errors++; $display("FAIL abort_out: got %h expected 0000", out1); end
        checks++; if (busy1 !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b expected 0", busy1); end
        checks++; if (done1 !== 1'b0)    begin errors++; $display("FAIL abort_done: got %b expected 0", done1); end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (done1 === 1'b1) dones++;
        end
        checks++; if (dones != 0)        begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
        run_op(SLL, 4'd3, 16'h0011, e, b);
        checks++; if (e != 3)            begin errors++; $display("FAIL abort_next_edges: got %0d expected 3", e); end
        checks++; if (out1 !== 16'h0088) begin errors++; $display("FAIL abort_next_out: got %h expected 0088", out1); end
    endtask

    task automatic test_back_to_back;
        int e, b;
        use4 = 1'b0; idle(16);
        run_op(SLL, 4'd2, 16'h0003, e, b);
        checks++; if (out1 !== 16'h000C) begin errors++; $display("FAIL b2b_first_out: got %h expected 000c", out1); end
        // Still in FIN: new request accepted on this edge.
        MODE = SRL; AMOUNT = 4'd1; INPUT = 16'h0011; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        checks++; if (busy1 !== 1'b1)    begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy1); end
        checks++; if (done1 !== 1'b0)    begin errors++; $display("FAIL b2b_done_low: got %b expected 0", done1); end
        checks++; if (out1 !== 16'h0011) begin errors++; $display("FAIL b2b_latched: got %h expected 0011", out1); end
        @(posedge CLK); #1;
        checks++; if (done1 !== 1'b1)    begin errors++; $display("FAIL b2b_done: got %b expected 1", done1); end
        checks++; if (out1 !== 16'h0008) begin errors++; $display("FAIL b2b_out: got %h expected 0008", out1); end
        checks++; if (carry1 !== 1'b1)   begin errors++; $display("FAIL b2b_carry: got %b expected 1", carry1); end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_right();
        test_rol_step4();
        test_zero_amount();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (≥2, power of 2).
REQ-002 SHALL have parameter STEP, default 1, maximum bits shifted per cycle (power of 2, 1..WIDTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  request; sampled on the rising edge of CLK.
REQ-006 SHALL have port MODE  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-007 SHALL have port AMOUNT  input  $clog2(WIDTH)  shift distance, 0..WIDTH-1.
REQ-008 SHALL have port INPUT  input  WIDTH  operand.
REQ-009 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse: OUTPUT/CARRY valid.
REQ-011 SHALL have port OUTPUT  output  WIDTH  result; registered, held until the next accepted START.
REQ-012 SHALL have port CARRY  output  1  last bit shifted or rotated out; 0 when AMOUNT=0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, FIN.
REQ-014 SHALL accept START in IDLE or FIN; at the accepting edge (edge 0) it latches INPUT, MODE and AMOUNT into working registers and clears CARRY.
REQ-015 SHALL go from accept to SHIFT when AMOUNT>0 and directly to FIN when AMOUNT=0 (OUTPUT=INPUT, CARRY=0).
REQ-016 In SHIFT, each edge SHALL shift by min(STEP, remaining) bits and decrement remaining by the same amount.
REQ-017 SHALL enter FIN on the edge that makes remaining 0, so for s=ceil(AMOUNT/STEP) DONE goes high after edge s.
REQ-018 SHALL assert DONE in FIN for exactly one cycle, then go FIN->IDLE unless START is sampled, in which case FIN->accept.
REQ-019 SHALL assert BUSY exactly in SHIFT; START while BUSY SHALL be ignored with no effect on latched operands.
REQ-020 SLL/SRL SHALL fill with zeros, SRA with the original MSB, and ROL SHALL wrap MSBs into the LSBs.
REQ-021 CARRY SHALL equal the final bit shifted out (SLL/ROL: MSB side; SRL/SRA: LSB side).
REQ-022 OUTPUT SHALL update only in the accept, SHIFT and FIN-entry cycles and SHALL never show a partial result while DONE=1.
REQ-023 Shifts SHALL be truncated to WIDTH bits; there is no overflow flag.

Reset
REQ-024 RST_N low SHALL immediately force state IDLE, BUSY=0, DONE=0, OUTPUT=0, CARRY=0, and clear remaining.
REQ-025 Reset during SHIFT or FIN SHALL abort the operation with no DONE pulse afterward; the first START after RST_N rises SHALL be accepted normally.

Structure
REQ-026 Mode codes (SLL/SRL/SRA/ROL) and FSM state encodings SHALL live in a shared package, shifter_pkg.
REQ-027 SHALL instantiate one combinational sub-module, shift_step, that shifts a WIDTH-bit word by k≤STEP bits in a given MODE and returns the result plus the outgoing bit.

Verification
REQ-028 WIDTH=16, STEP=1, SLL, AMOUNT=1, INPUT=100 -> DONE after edge 1, OUTPUT=200, CARRY=0; INPUT=0xFFFF -> OUTPUT=0xFFFE, CARRY=1.
REQ-029 STEP=1, SRA, AMOUNT=15, INPUT=0x8000 -> BUSY for 15 cycles, DONE after edge 15, OUTPUT=0xFFFF, CARRY=0.
REQ-030 STEP=4, ROL, AMOUNT=4, INPUT=0x8001 -> DONE after edge 1, OUTPUT=0x0018, CARRY=0; with AMOUNT=6 -> DONE after edge 2, OUTPUT=0x0060.
REQ-031 AMOUNT=0, INPUT=0x1234, any MODE -> BUSY never high, DONE after edge 0, OUTPUT=0x1234, CARRY=0.
REQ-032 START with INPUT=0x0001, SLL, AMOUNT=8, then START with INPUT=0xFFFF at edge 3 -> second request ignored, OUTPUT=0x0100.
REQ-033 RST_N pulsed low at edge 3 of an 8-step operation -> outputs 0 immediately, no DONE; a new START then completes correctly.
